// File: rtl/vector_issue_if.sv
// Issue-controller bus bundle: decode handshake, execute drive/return and
// writeback handshake. "slave" is the controller view, "master" the
// surrounding pipeline (decode, execute and writeback) view.
interface vector_issue_if #(
  parameter int N            = 32,
  parameter int WIDTH_VECTOR = 24,
  parameter int WIDTH_OPCODE = 4
);
  // decode -> controller
  logic                                 in_valid;
  logic                                 in_ready;
  logic        [WIDTH_OPCODE-1:0]       in_opcode;
  logic        [WIDTH_VECTOR-1:0]       in_mask;
  logic signed [WIDTH_VECTOR*N-1:0]     in_dataA;
  logic signed [WIDTH_VECTOR*N-1:0]     in_dataB;
  logic signed [WIDTH_VECTOR-1:0]       in_imm;
  // controller -> execute
  logic        [WIDTH_VECTOR-1:0]       enable_alu;
  logic        [WIDTH_OPCODE-1:0]       opcode;
  logic signed [WIDTH_VECTOR*N-1:0]     dataA;
  logic signed [WIDTH_VECTOR*N-1:0]     dataB;
  logic signed [WIDTH_VECTOR-1:0]       data_imm;
  // execute -> controller
  logic                                 exe_valid;
  logic                                 exe_zero;
  logic signed [WIDTH_VECTOR*N-1:0]     exe_data;
  // controller -> writeback
  logic                                 wb_valid;
  logic                                 wb_ready;
  logic signed [WIDTH_VECTOR*N-1:0]     wb_data;
  logic                                 wb_zero;
  logic                                 wb_timeout;
  logic                                 busy;

  modport slave (
    input  in_valid, in_opcode, in_mask, in_dataA, in_dataB, in_imm,
    input  exe_valid, exe_zero, exe_data, wb_ready,
    output in_ready, enable_alu, opcode, dataA, dataB, data_imm,
    output wb_valid, wb_data, wb_zero, wb_timeout, busy
  );

  modport master (
    output in_valid, in_opcode, in_mask, in_dataA, in_dataB, in_imm,
    output exe_valid, exe_zero, exe_data, wb_ready,
    input  in_ready, enable_alu, opcode, dataA, dataB, data_imm,
    input  wb_valid, wb_data, wb_zero, wb_timeout, busy
  );
endinterface

// File: rtl/vector_issue.sv
// Vector issue controller: accepts one decoded instruction, holds it on the
// execute inputs until execute completes (or a cycle budget expires), then
// offers the captured result to writeback.
module vector_issue #(
  parameter int N            = 32,
  parameter int WIDTH_VECTOR = 24,
  parameter int WIDTH_OPCODE = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          rstn,
  vector_issue_if.slave bus
);
  localparam int VW    = WIDTH_VECTOR * N;
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  logic        [1:0]              state_q;
  logic        [CNT_W-1:0]        cnt_q;

  logic        [WIDTH_OPCODE-1:0] op_p0;
  logic        [WIDTH_VECTOR-1:0] mask_p0;
  logic signed [VW-1:0]           data_a_p0;
  logic signed [VW-1:0]           data_b_p0;
  logic signed [WIDTH_VECTOR-1:0] imm_p0;

  logic signed [VW-1:0]           wb_data_p1;
  logic                           wb_zero_p1;
  logic                           wb_timeout_p1;

  logic accept;
  logic timeout_hit;

  assign accept      = bus.in_valid && (state_q == IDLE);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Control FSM: IDLE -> EXEC on accept, EXEC -> RESP on completion or
  // budget expiry, RESP -> IDLE when writeback takes the result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_q <= EXEC;
        EXEC:    if (bus.exe_valid || timeout_hit) state_q <= RESP;
        RESP:    if (bus.wb_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Cycles spent in EXEC; starts at 0 for the first EXEC cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == EXEC) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Stage p0: instruction holding register, loaded only on accept so the
  // execute inputs stay constant through EXEC and keep their last value after.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_p0     <= '0;
      mask_p0   <= '0;
      data_a_p0 <= '0;
      data_b_p0 <= '0;
      imm_p0    <= '0;
    end else if (accept) begin
      op_p0     <= bus.in_opcode;
      mask_p0   <= bus.in_mask;
      data_a_p0 <= bus.in_dataA;
      data_b_p0 <= bus.in_dataB;
      imm_p0    <= bus.in_imm;
    end
  end

  // Stage p1: result capture; a real completion beats an expiring budget.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_data_p1    <= '0;
      wb_zero_p1    <= 1'b0;
      wb_timeout_p1 <= 1'b0;
    end else if (state_q == EXEC) begin
      if (bus.exe_valid) begin
        wb_data_p1    <= bus.exe_data;
        wb_zero_p1    <= bus.exe_zero;
        wb_timeout_p1 <= 1'b0;
      end else if (timeout_hit) begin
        wb_data_p1    <= '0;
        wb_zero_p1    <= 1'b0;
        wb_timeout_p1 <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.wb_valid   = (state_q == RESP);
  assign bus.enable_alu = (state_q == EXEC) ? mask_p0 : '0;
  assign bus.opcode     = op_p0;
  assign bus.dataA      = data_a_p0;
  assign bus.dataB      = data_b_p0;
  assign bus.data_imm   = imm_p0;
  assign bus.wb_data    = wb_data_p1;
  assign bus.wb_zero    = wb_zero_p1;
  assign bus.wb_timeout = wb_timeout_p1;
endmodule

// File: tb/tb_vector_issue.sv
// Testbench for vector_issue: directed scenarios plus randomized instructions
// checked against a transaction-level model of completion latency and result.
module tb_vector_issue;
  localparam int N  = 32;
  localparam int WV = 24;
  localparam int WO = 4;
  localparam int TO = 8;
  localparam int VW = N * WV;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  vector_issue_if #(.N(N), .WIDTH_VECTOR(WV), .WIDTH_OPCODE(WO)) bus ();

  vector_issue #(.N(N), .WIDTH_VECTOR(WV), .WIDTH_OPCODE(WO), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rvec();
    logic [VW-1:0] v;
    for (int i = 0; i < WV; i++) v[i*N +: N] = N'($urandom);
    return v;
  endfunction

  task automatic drive_junk();
    bus.in_opcode = WO'($urandom);
    bus.in_mask   = WV'($urandom);
    bus.in_dataA  = rvec();
    bus.in_dataB  = rvec();
    bus.in_imm    = WV'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction: execute answers after d silent EXEC cycles (d >= TO
  // means never), writeback stalls s cycles before accepting.
  task automatic run_op(input logic [WO-1:0] op, input logic [WV-1:0] mk,
                        input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input logic [WV-1:0] im, input int d, input int s,
                        input logic [VW-1:0] res, input logic zres);
    int            exec_len;
    logic [VW-1:0] exp_data;
    logic          exp_zero;
    logic          exp_to;
    check("in_ready_idle", VW'(bus.in_ready), VW'(1'b1));
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_mask   = mk;
    bus.in_dataA  = a;
    bus.in_dataB  = b;
    bus.in_imm    = im;
    bus.exe_valid = 1'($urandom);
    bus.exe_data  = rvec();
    bus.wb_ready  = 1'($urandom);
    tick();
    if (d < TO) begin
      exec_len = d + 1;
      exp_data = res;
      exp_zero = zres;
      exp_to   = 1'b0;
    end else begin
      exec_len = TO;
      exp_data = '0;
      exp_zero = 1'b0;
      exp_to   = 1'b1;
    end
    for (int c = 1; c <= exec_len; c++) begin
      check("exec_enable", VW'(bus.enable_alu), VW'(mk));
      check("exec_opcode", VW'(bus.opcode), VW'(op));
      check("exec_dataA", bus.dataA, a);
      check("exec_dataB", bus.dataB, b);
      check("exec_imm", VW'($unsigned(bus.data_imm)), VW'(im));
      check("exec_in_ready", VW'(bus.in_ready), VW'(1'b0));
      check("exec_wb_valid", VW'(bus.wb_valid), VW'(1'b0));
      check("exec_busy", VW'(bus.busy), VW'(1'b1));
      drive_junk();
      bus.in_valid = 1'($urandom);
      bus.wb_ready = 1'($urandom);
      if (c - 1 == d) begin
        bus.exe_valid = 1'b1;
        bus.exe_data  = res;
        bus.exe_zero  = zres;
      end else begin
        bus.exe_valid = 1'b0;
        bus.exe_data  = rvec();
        bus.exe_zero  = 1'($urandom);
      end
      tick();
    end
    for (int r = 0; r <= s; r++) begin
      check("resp_wb_valid", VW'(bus.wb_valid), VW'(1'b1));
      check("resp_wb_data", bus.wb_data, exp_data);
      check("resp_wb_zero", VW'(bus.wb_zero), VW'(exp_zero));
      check("resp_wb_timeout", VW'(bus.wb_timeout), VW'(exp_to));
      check("resp_enable", VW'(bus.enable_alu), VW'(0));
      check("resp_in_ready", VW'(bus.in_ready), VW'(1'b0));
      check("resp_opcode", VW'(bus.opcode), VW'(op));
      check("resp_dataA", bus.dataA, a);
      bus.exe_valid = 1'($urandom);
      bus.exe_zero  = 1'($urandom);
      bus.exe_data  = rvec();
      bus.wb_ready  = (r == s);
      if (r == s) begin
        bus.in_valid = 1'b0;
      end else begin
        drive_junk();
        bus.in_valid = 1'($urandom);
      end
      tick();
    end
    check("post_in_ready", VW'(bus.in_ready), VW'(1'b1));
    check("post_busy", VW'(bus.busy), VW'(1'b0));
    check("post_wb_valid", VW'(bus.wb_valid), VW'(1'b0));
    check("post_enable", VW'(bus.enable_alu), VW'(0));
    check("post_opcode", VW'(bus.opcode), VW'(op));
    check("post_imm", VW'($unsigned(bus.data_imm)), VW'(im));
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_in_ready"}, VW'(bus.in_ready), VW'(1'b1));
    check({pfx, "_busy"}, VW'(bus.busy), VW'(1'b0));
    check({pfx, "_wb_valid"}, VW'(bus.wb_valid), VW'(1'b0));
    check({pfx, "_wb_data"}, bus.wb_data, '0);
    check({pfx, "_wb_zero"}, VW'(bus.wb_zero), VW'(1'b0));
    check({pfx, "_wb_timeout"}, VW'(bus.wb_timeout), VW'(1'b0));
    check({pfx, "_enable"}, VW'(bus.enable_alu), VW'(0));
    check({pfx, "_opcode"}, VW'(bus.opcode), VW'(0));
    check({pfx, "_dataA"}, bus.dataA, '0);
    check({pfx, "_dataB"}, bus.dataB, '0);
    check({pfx, "_imm"}, VW'($unsigned(bus.data_imm)), VW'(0));
  endtask

  initial begin
    logic [VW-1:0] res;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [WV-1:0] mk;

    // reset held with random inputs
    drive_junk();
    bus.in_valid  = 1'b1;
    bus.exe_valid = 1'b1;
    bus.exe_zero  = 1'b1;
    bus.exe_data  = rvec();
    bus.wb_ready  = 1'b1;
    rstn = 1'b0;
    tick();
    tick();
    check_reset_values("rst");
    bus.in_valid = 1'b0;
    rstn = 1'b1;
    tick();
    check("rel_in_ready", VW'(bus.in_ready), VW'(1'b1));
    check("rel_busy", VW'(bus.busy), VW'(1'b0));

    // single op, Q16.16 1.5 in lane 0
    res = rvec();
    res[N-1:0] = 32'h0001_8000;
    run_op(4'b0100, 24'hFFFFFF, rvec(), rvec(), WV'($urandom), 0, 0, res, 1'b0);
    // multi-cycle with zero flag
    run_op(4'h3, WV'($urandom), rvec(), rvec(), WV'($urandom), 5, 0, rvec(), 1'b1);
    // backpressure
    run_op(4'h7, WV'($urandom), rvec(), rvec(), WV'($urandom), 2, 10, rvec(), 1'b1);
    // timeout, and completion on the last budgeted cycle
    run_op(4'h9, WV'($urandom), rvec(), rvec(), WV'($urandom), 1000, 1, rvec(), 1'b1);
    run_op(4'hA, WV'($urandom), rvec(), rvec(), WV'($urandom), TO - 1, 0, rvec(), 1'b1);
    // mask of zero completes normally
    run_op(4'h1, '0, rvec(), rvec(), WV'($urandom), 0, 0, rvec(), 1'b0);

    // reset during the third EXEC cycle
    a = rvec();
    bus.in_valid  = 1'b1;
    bus.in_opcode = 4'hC;
    bus.in_mask   = 24'h00FF00;
    bus.in_dataA  = a;
    bus.exe_valid = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("mid_enable_before", VW'(bus.enable_alu), VW'(24'h00FF00));
    #2 rstn = 1'b0;
    #1;
    check_reset_values("mid");
    bus.exe_valid = 1'b1;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_no_wb_valid", VW'(bus.wb_valid), VW'(1'b0));
      check("mid_idle", VW'(bus.in_ready), VW'(1'b1));
    end
    bus.exe_valid = 1'b0;

    // randomized instructions
    for (int t = 0; t < 40; t++) begin
      mk = ($urandom_range(0, 4) == 0) ? '0 : WV'($urandom);
      a  = rvec();
      b  = rvec();
      run_op(WO'($urandom), mk, a, b, WV'($urandom),
             int'($urandom_range(0, TO + 2)), int'($urandom_range(0, 3)),
             rvec(), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
